fetch_unit: RTL

//  Instruction-fetch stage of the RV32I 5-stage pipeline; sits upstream of the ID stage.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/pc_next_sel.sv | 44 ++++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: XLEN, bubble encoding, fetch FSM states,
// fetch fault codes and the IF/ID register layout.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fault_code_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage, with redirect alignment and
// IMEM range checks. Purely combinational.
module pc_next_sel
    import rv32_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output fault_code_e     fault_code_o
);

    localparam logic [XLEN-1:0] WORDS_W = XLEN'(IMEM_WORDS);

    logic [XLEN-1:0] word_idx;
    logic            out_of_range;
    logic            misaligned;

    assign word_idx     = {2'b00, pc_i[XLEN-1:2]};
    assign out_of_range = (word_idx >= WORDS_W);
    assign misaligned   = (branch_target_i[1:0] != 2'b00);

    // The range check only applies to sequential fetch; a redirect replaces the PC.
    always_comb begin
        next_pc_o    = pc_i;
        fault_code_o = FLT_NONE;
        if (branch_taken_i) begin
            next_pc_o = branch_target_i;
            if (misaligned) begin
                fault_code_o = FLT_MISALIGN;
            end
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else if (out_of_range) begin
            fault_code_o = FLT_RANGE;
        end else begin
            next_pc_o = pc_i + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, reads IMEM combinationally and
// fills the IF/ID register; halts on misaligned redirects or out-of-range PC.
//
// state    | meaning
// ST_RUN   | fetching, honouring redirect and stall
// ST_FAULT | fetch halted with a sticky fault code, left only by reset
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] i_mem_addr_o,
    input  logic [XLEN-1:0] i_mem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            fault_o,
    output logic [1:0]      fault_code_o,
    output logic [XLEN-1:0] fetch_count_o
);

    localparam if_id_t BUBBLE = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    fault_code_e     code_q, code_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [XLEN-1:0] sel_next_pc;
    fault_code_e     sel_fault;

    pc_next_sel #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_next_sel (
        .pc_i            (pc_q),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .next_pc_o       (sel_next_pc),
        .fault_code_o    (sel_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            if_id_q <= BUBBLE;
            code_q  <= FLT_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        code_d  = code_q;
        count_d = count_q;
        unique case (state_q)
            ST_RUN: begin
                if (branch_taken_i) begin
                    // Flush the wrong-path instruction; a misaligned target also halts.
                    pc_d    = sel_next_pc;
                    if_id_d = BUBBLE;
                    if (sel_fault == FLT_MISALIGN) begin
                        state_d = ST_FAULT;
                        code_d  = FLT_MISALIGN;
                    end
                end else if (!stall_i) begin
                    if (sel_fault == FLT_RANGE) begin
                        if_id_d = BUBBLE;
                        state_d = ST_FAULT;
                        code_d  = FLT_RANGE;
                    end else begin
                        if_id_d = {pc_q, i_mem_rdata_i, 1'b1};
                        pc_d    = sel_next_pc;
                        count_d = count_q + XLEN'(1);
                    end
                end
            end
            ST_FAULT: begin
                if_id_d.valid = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign i_mem_addr_o  = pc_q;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;
    assign fault_o       = (state_q == ST_FAULT);
    assign fault_code_o  = code_q;
    assign fetch_count_o = count_q;

endmodule
